pc_unit: RTL

- Parametrised next-generation program counter for the RISC core's fetch stage.
- Generalises address width, reset/exception vectors and supervisor-bit protection.
- Adds a fetch stall, an exception return-address register (XP capture) and a configurable-depth return-address stack (RAS) for call/return.
- Sits between the control unit (PCSEL, stall, push/pop) and instruction memory/register file (pc_o, PcIncr, xp_o).

---
 rtl/pc_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// Fetch-stage program counter: next-PC select with supervisor-bit protection,
// exception return-address capture and a circular return-address stack.
module pc_unit #(
  parameter int unsigned        ADDR_W    = 32,
  parameter int unsigned        RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0]  RST_ADDR  = '0
) (
  input  logic              clk,
  input  logic              RESET_N,
  input  logic              STALL,
  input  logic [2:0]        PCSEL,
  input  logic [ADDR_W-1:0] XAddr,
  input  logic [ADDR_W-1:0] IllOpAddr,
  input  logic [ADDR_W-1:0] JT,
  input  logic [ADDR_W-1:0] ShftSextC,
  input  logic              RAS_PUSH,
  input  logic              RAS_POP,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] PcIncr,
  output logic [ADDR_W-1:0] branchOffset,
  output logic [ADDR_W-1:0] xp_o,
  output logic [ADDR_W-1:0] ras_top,
  output logic              ras_valid,
  output logic              ras_ovf
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned MSB   = ADDR_W - 1;

  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(RAS_DEPTH);
  localparam logic [ADDR_W-1:0] S_MASK   = {1'b1, {(ADDR_W-1){1'b0}}};

  localparam logic [2:0] SEL_INCR = 3'b000;
  localparam logic [2:0] SEL_BR   = 3'b001;
  localparam logic [2:0] SEL_JMP  = 3'b010;
  localparam logic [2:0] SEL_ILL  = 3'b011;
  localparam logic [2:0] SEL_XCPT = 3'b100;
  localparam logic [2:0] SEL_RET  = 3'b101;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] xp_q, xp_d;
  logic [ADDR_W-1:0] top_q, top_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic              mem_we;
  logic [PTR_W-1:0]  mem_waddr;
  logic              pop_req;
  logic              ras_nonempty;
  logic [PTR_W-1:0]  top_ptr;
  logic [PTR_W-1:0]  below_ptr;
  logic              s_bit;

  assign PcIncr       = pc_q + ADDR_W'(4);
  assign branchOffset = PcIncr + ShftSextC;
  assign s_bit        = pc_q[MSB];
  assign ras_nonempty = (cnt_q != '0);
  assign top_ptr      = wr_ptr_q - PTR_W'(1);
  assign below_ptr    = wr_ptr_q - PTR_W'(2);

  assign pc_o      = pc_q;
  assign xp_o      = xp_q;
  assign ras_top   = top_q;
  assign ras_valid = valid_q;
  assign ras_ovf   = ovf_q;

  // Next-PC selection and RAS bookkeeping; a stall leaves every default in place.
  always_comb begin
    pc_d      = pc_q;
    xp_d      = xp_q;
    top_d     = top_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = wr_ptr_q;
    pop_req   = 1'b0;

    if (!STALL) begin
      case (PCSEL)
        SEL_INCR: pc_d = {s_bit, PcIncr[MSB-1:0]};
        SEL_BR:   pc_d = {s_bit, branchOffset[MSB-1:0]};
        SEL_JMP:  pc_d = {s_bit & JT[MSB], JT[MSB-1:0]};
        SEL_ILL: begin
          pc_d = IllOpAddr | S_MASK;
          xp_d = PcIncr;
        end
        SEL_XCPT: begin
          pc_d = XAddr | S_MASK;
          xp_d = PcIncr;
        end
        SEL_RET: begin
          // A return with nothing on the stack is treated as an illegal op.
          if (ras_nonempty) begin
            pc_d = {s_bit & top_q[MSB], top_q[MSB-1:0]};
          end else begin
            pc_d = IllOpAddr | S_MASK;
            xp_d = PcIncr;
          end
        end
        default:  pc_d = RST_ADDR;
      endcase

      pop_req = RAS_POP | ((PCSEL == SEL_RET) & ras_nonempty);

      if (RAS_PUSH && pop_req && ras_nonempty) begin
        mem_we    = 1'b1;
        mem_waddr = top_ptr;
        top_d     = PcIncr;
      end else if (RAS_PUSH) begin
        // When full, the write slot is the oldest entry, so it is overwritten.
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        top_d    = PcIncr;
        valid_d  = 1'b1;
        if (cnt_q == CNT_FULL) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else if (pop_req && ras_nonempty) begin
        wr_ptr_d = top_ptr;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q > CNT_W'(1)) begin
          top_d = ras_mem[below_ptr];
        end else begin
          top_d   = '0;
          valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      pc_q     <= RST_ADDR;
      xp_q     <= '0;
      top_q    <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      xp_q     <= xp_d;
      top_q    <= top_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Stack storage needs no reset; the count qualifies every entry.
  always_ff @(posedge clk) begin
    if (RESET_N && mem_we) begin
      ras_mem[mem_waddr] <= PcIncr;
    end
  end

endmodule
